seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexing scan controller for the board's common-anode 4-digit 7-segment display. It holds a multi-digit hex/BCD value and presents one nibble per slot to the downstream registered BCD-to-7-segment decoder. It drives the active-low anode enables in step with that decoder's one-cycle output latency and inserts a blanking gap between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so the display never shows a torn value.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; digit 0 is rightmost.
- REFRESH_DIV, 100000: clock cycles per digit slot, 1 ms at 100 MHz.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off. Legal range is 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- value, input, 4*NUM_DIGITS: value to display. value[4k+3:4k] is digit k.
- load, input, 1: one-cycle strobe that captures value into the shadow register.
- bcd, output, 4: nibble sent to the decoder's bcd input.
- an, output, NUM_DIGITS: anode enables, active-low. an[k] drives digit k.
- digit_idx, output, clog2(NUM_DIGITS): index of the slot currently being scanned.
- pending, output, 1: the shadow holds a value not yet committed.
- frame_done, output, 1: one-cycle pulse at every frame boundary.

## Operation
- Registers:
  - active (displayed value)
  - shadow
  - pending
  - slot counter cnt, 0..REFRESH_DIV-1
  - digit_idx
  - two-state FSM: BLANK, SHOW
- FSM:
  - BLANK holds while cnt < BLANK_CYCLES, with an all ones. BLANK → SHOW when cnt reaches BLANK_CYCLES.
  - SHOW drives an = ~(1 << digit_idx). SHOW → BLANK when cnt = REFRESH_DIV-1; at that edge cnt wraps to 0 and digit_idx advances.
- bcd = active[4*digit_idx +: 4]. It is updated on the same edge digit_idx advances, so it is stable for the whole slot.
- Decoder alignment: the decoder needs one cycle after bcd changes. Because BLANK_CYCLES ≥ 1, segments are valid before any anode turns on.
- Wrap: digit_idx goes NUM_DIGITS-1 → 0. This edge is the frame boundary.
- Load handling:
  - load=1 captures value into shadow and sets pending.
  - A repeat load while pending is set overwrites shadow; the last load wins.
- Frame boundary actions:
  - If pending, active ← shadow and pending clears.
  - frame_done pulses high for one cycle.
- Load on the boundary cycle: the value presented that cycle is committed directly to active, and pending stays 0.
- Arithmetic: cnt is clog2(REFRESH_DIV) bits wide, with an explicit compare-and-wrap. There is no reliance on power-of-two overflow.
- Reset values: an all ones, bcd 0, digit_idx 0, active 0, shadow 0, pending 0, frame_done 0, cnt 0, state BLANK.
- Reset mid-slot or mid-frame: on the next clock edge, all registers return to reset values and a pending load is discarded.

## Timing
- Slot length is exactly REFRESH_DIV cycles. The anode is low for REFRESH_DIV-BLANK_CYCLES of them.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- The first anode goes low BLANK_CYCLES cycles after reset is released.
- Load-to-display latency is at most one frame plus BLANK_CYCLES cycles.
- pending asserts the cycle after load.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: in SHOW, an[k] stays high when digit k and every more-significant digit of active are 0. Digit 0 is always shown, so an all-zero value displays a single "0".
  - Undefined: every digit is lit in its slot.
- Scan timing, bcd, digit_idx and frame_done are identical in both builds.

## Structure
- Shared package seg7_pkg holds:
  - the scan_state_e enum (BLANK, SHOW)
  - the default REFRESH_DIV and BLANK_CYCLES constants
  - the anode-off constant
- One sub-module, seg7_slot_timer, provides cnt with a wrap pulse and the FSM. The top level holds the buffering, digit indexing and anode decode.
- The decoder is instantiated beside this block at the board top, not inside it.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then idle: an=4'b1111 for 2 cycles, then 4'b1110 for 6. The pattern steps to 4'b1101, 4'b1011, 4'b0111. frame_done pulses every 32 cycles; bcd=0 throughout.
- load with value=16'h1A3F mid-frame: pending=1 next cycle. At the next boundary active=16'h1A3F and pending=0. Per slot, bcd reads F, 3, A, 1.
- Two loads in one frame (16'h1111, then 16'h2222): only 16'h2222 is displayed, and 16'h1111 never appears on bcd.
- load with value=16'hBEEF on the boundary cycle: active=16'hBEEF on that edge, pending stays 0, and digit 0 shows F.
- rst_n low for one cycle mid-SHOW with pending=1: the next cycle shows reset values, and the load is lost.
- LEADING_ZERO_BLANK_EN build with value=16'h0050: an[3] and an[2] stay high in their slots, and an[1] and an[0] go low. With value=16'h0000, only digit 0 lights.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and defaults for the 7-segment scan controller
package seg7_pkg;
  typedef enum logic {BLANK, SHOW} scan_state_e;
  localparam int REFRESH_DIV_DEF = 100000;
  localparam int BLANK_CYCLES_DEF = 2;
  localparam logic AN_OFF = 1'b1;
endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: per-slot cycle counter with BLANK/SHOW phase FSM
module seg7_slot_timer import seg7_pkg::*; #(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap,
  output logic show_nx
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  scan_state_e state;
  always_comb begin
    wrap = cnt == CW'(REFRESH_DIV - 1);
    show_nx = state == BLANK ? cnt == CW'(BLANK_CYCLES - 1) : !wrap;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      state <= BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      state <= show_nx ? SHOW : BLANK;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered 7-seg digit scanner (LEADING_ZERO_BLANK_EN blanks leading-zero digits)
module seg7_scan_ctrl import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    pending,
  output logic                    frame_done
);
  logic [4*NUM_DIGITS-1:0] active, shadow, active_nx;
  logic [NUM_DIGITS-1:0] vis;
  logic [IW-1:0] idx_nx;
  logic wrap, show_nx, boundary;
  seg7_slot_timer #(.REFRESH_DIV(REFRESH_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .wrap(wrap),
    .show_nx(show_nx)
  );
  always_comb begin
    boundary = wrap && digit_idx == IW'(NUM_DIGITS - 1);
    active_nx = !boundary ? active : load ? value : pending ? shadow : active;
    idx_nx = !wrap ? digit_idx : boundary ? '0 : digit_idx + 1'b1;
  end
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic nz;
    nz = 1'b0;
    vis = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz = nz | (|active[4*k +: 4]);
      vis[k] = nz || k == 0;
    end
  end
`else
  assign vis = '1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= '0;
      shadow <= '0;
      pending <= 1'b0;
      digit_idx <= '0;
      bcd <= '0;
      an <= {NUM_DIGITS{AN_OFF}};
      frame_done <= 1'b0;
    end else begin
      active <= active_nx;
      shadow <= load ? value : shadow;
      pending <= boundary ? 1'b0 : load ? 1'b1 : pending;
      digit_idx <= idx_nx;
      bcd <= active_nx[{idx_nx, 2'b00} +: 4];
      an <= show_nx ? ~(vis & (NUM_DIGITS'(1) << digit_idx)) : {NUM_DIGITS{AN_OFF}};
      frame_done <= boundary;
    end
  end
endmodule
